qreg_ctrl: RTL and testbench
============================

// Module: qreg_ctrl
// PURPOSE
//   Command sequencer for the N-bit Q register datapath (rst/ldp/cta/l_and controls).
//   Accepts one command at a time over a valid/ready handshake and drives the matching control strobes.
//   Supported commands: clear, load, count-by-K and AND-mask.
//   Signals completion with a one-cycle done pulse.
//   Sits between the top-level switch/button logic and the Q register.
// PARAMETERS
//   N  8  datapath width; also the width of cmd_arg, sw_out, q_in and the count counter
// PORTS
//   clk        in   1  system clock
//   rst        in   1  synchronous, active-high reset
//   cmd_valid  in   1  command present
//   cmd_ready  out  1  controller can accept a command (IDLE only)
//   cmd_op     in   2  opcode, qreg_ctrl_pkg::op_e
//   cmd_arg    in   N  operand for LOAD/AND; repeat count K for COUNT
//   abort      in   1  terminate an in-progress COUNT
//   q_in       in   N  current Q register value (Qout)
//   q_clr      out  1  clear strobe to Q register rst
//   ldp        out  1  load strobe
//   cta        out  1  increment strobe
//   l_and      out  1  AND strobe
//   sw_out     out  N  operand to Q register SW input
//   busy       out  1  high in every state except IDLE
//   done       out  1  one-cycle completion pulse
//   aborted    out  1  qualifies done: COUNT ended by abort
//   wrapped    out  1  qualifies done: COUNT stopped at all-ones (macro only)
// BEHAVIOUR
//   - Clock and reset: clk only; rst is synchronous and active-high.
//   - Reset: state=IDLE, counter=0, sw_out=0. All strobes, done, aborted, wrapped and busy are 0.
//     cmd_ready is 0 during the reset cycle.
//   - Reset mid-operation: the command is discarded with no done pulse. Outputs are at reset values the next cycle.
//   - Handshake: a command is accepted when cmd_valid&&cmd_ready. cmd_ready = (state==IDLE).
//     On acceptance, latch op and arg; sw_out <= cmd_arg and holds until the next accept.
//   - FSM states: IDLE, CLR, LOAD, AND, COUNT, DONE.
//   - Transitions: IDLE -> {CLR, LOAD, AND, COUNT} per op. CLR/LOAD/AND -> DONE after 1 cycle.
//     COUNT -> DONE when remaining==0, on abort, or on wrap. DONE -> IDLE.
//   - Strobes are registered-state decodes and one-hot:
//     q_clr=(CLR), ldp=(LOAD), l_and=(AND), cta=(COUNT && remaining!=0 && !abort && !stop).
//     Never more than one strobe high in a cycle.
//   - Single-cycle op timing: accept at cycle t; strobe at t+1; done at t+2; cmd_ready again at t+3.
//   - COUNT K timing: remaining <= K on accept. cta is high for cycles t+1..t+K and remaining decrements on each cta.
//     done at t+K+1.
//   - COUNT with K=0: no cta is issued; COUNT -> DONE at t+1; done at t+2.
//   - Count width: remaining is N bits unsigned; K up to 2^N-1. The Q register wraps naturally.
//   - abort: sampled in COUNT only, ignored in all other states.
//     In the abort cycle cta=0 and the next state is DONE; done and aborted are asserted together.
//   - done, aborted and wrapped are high only in DONE; aborted and wrapped are 0 otherwise.
//   - Simultaneous abort and wrap: abort wins (aborted=1, wrapped=0).
//   - Unknown opcodes cannot occur: the 2-bit op_e enum is fully decoded.
// CONFIGURATION
//   QREG_CTRL_WRAP_STOP_EN defined:
//     - In COUNT, if q_in=='1 in a cycle where cta would be issued, cta is suppressed and the next state is DONE.
//       The Q register therefore never wraps.
//     - done is asserted with wrapped=1.
//   QREG_CTRL_WRAP_STOP_EN undefined:
//     - q_in is unused; wrapped is tied to 0.
//     - COUNT always issues K pulses unless aborted.
// STRUCTURE
//   - qreg_ctrl_pkg (shared package):
//     - op_e: OP_CLR=2'b00, OP_LOAD=2'b01, OP_COUNT=2'b10, OP_AND=2'b11
//     - state_e
//     - Q_WIDTH_DEFAULT=8
//   - Sub-module qreg_ctrl_cnt: N-bit loadable down-counter (load, dec, zero flag). Used for remaining.
//   - The FSM and strobe decode stay in qreg_ctrl. The bench pairs the controller with the Q register as a reference model.
// TESTING
//   1 After reset, LOAD 0xA5 accepted at t: ldp=1 and sw_out=0xA5 at t+1; done at t+2; Q=0xA5; cmd_ready=1 at t+3.
//   2 Q=0x10, COUNT 3: cta high exactly 3 consecutive cycles; done on the following cycle; Q=0x13; aborted=0.
//   3 COUNT 0: no cta pulse; done at t+2; Q unchanged. Then CLR: q_clr for 1 cycle; Q=0x00.
//   4 Q=0xA5, AND 0x0F: l_and for 1 cycle; Q=0x05.
//     Check on every cycle: strobes are one-hot and cmd_ready=0 while busy.
//   5 COUNT 10 from Q=0; abort asserted after the 4th cta: exactly 4 cta; done with aborted=1; Q=0x04.
//     abort asserted in IDLE has no effect.
//   6 Macro on: LOAD 0xFD, COUNT 5: 2 cta; done with wrapped=1; Q=0xFF.
//     rst asserted mid-COUNT: all outputs 0 next cycle; no done pulse.

Source files
------------

// File: rtl/qreg_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// qreg_ctrl_pkg
//   Shared types and constants for the Q register command sequencer.
//   - op_e    : 2-bit command opcode, fully decoded (no illegal values).
//   - state_e : sequencer FSM state encoding, also exported on dbg_state.
//   - Q_WIDTH_DEFAULT : default datapath width.
//   - op_to_state     : maps an accepted opcode to its first working state.
// -----------------------------------------------------------------------------
package qreg_ctrl_pkg;

    localparam int Q_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        OP_CLR   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_COUNT = 2'b10,
        OP_AND   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_AND   = 3'd3,
        ST_COUNT = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    function automatic state_e op_to_state(input op_e op);
        state_e st;
        st = ST_CLR;
        case (op)
            OP_CLR:   st = ST_CLR;
            OP_LOAD:  st = ST_LOAD;
            OP_COUNT: st = ST_COUNT;
            OP_AND:   st = ST_AND;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/qreg_ctrl_cnt.sv
// -----------------------------------------------------------------------------
// qreg_ctrl_cnt
//   N-bit loadable down-counter holding the number of increments still owed
//   by a COUNT command.
// Ports
//   clk         in  1  system clock
//   rst         in  1  synchronous, active-high reset (count -> 0)
//   i_load      in  1  load i_load_val (has priority over i_dec)
//   i_load_val  in  N  value to load
//   i_dec       in  1  decrement by one (ignored when already zero)
//   o_zero      out 1  count == 0
//   o_last      out 1  count == 1 (the next decrement empties it)
// -----------------------------------------------------------------------------
module qreg_ctrl_cnt #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [N-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero,
    output logic         o_last
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            // Guarded so a stray decrement can never underflow to all-ones.
            r_count <= r_count - ONE;
        end
    end

    assign o_zero = (r_count == '0);
    assign o_last = (r_count == ONE);

endmodule

// File: rtl/qreg_ctrl.sv
// -----------------------------------------------------------------------------
// qreg_ctrl
//   Command sequencer for the N-bit Q register datapath. Takes one command at
//   a time (clear, load, count-by-K, AND-mask) and drives the matching one-hot
//   control strobe, then pulses done for one cycle.
//
//   Handshake: a command transfers on a cycle where cmd_valid && cmd_ready
//   are both high at the rising edge; cmd_ready is high only in IDLE (and low
//   while rst is asserted), the command fields need only be stable in that
//   cycle, and the sequencer holds no further obligation to the requester
//   until it returns to IDLE.
//
// Build option
//   QREG_CTRL_WRAP_STOP_EN : when defined, COUNT stops early (wrapped=1)
//   rather than increment a Q register that already reads all-ones. When
//   undefined, q_in is ignored and wrapped is tied low.
//
// Ports
//   clk        in   1  system clock
//   rst        in   1  synchronous, active-high reset
//   cmd_valid  in   1  command present
//   cmd_ready  out  1  controller can accept a command (IDLE only)
//   cmd_op     in   2  opcode (op_e)
//   cmd_arg    in   N  operand for LOAD/AND; repeat count K for COUNT
//   abort      in   1  terminate an in-progress COUNT
//   q_in       in   N  current Q register value
//   q_clr      out  1  clear strobe
//   ldp        out  1  load strobe
//   cta        out  1  increment strobe
//   l_and      out  1  AND strobe
//   sw_out     out  N  operand to the Q register, held from accept to accept
//   busy       out  1  high in every state except IDLE
//   done       out  1  one-cycle completion pulse
//   aborted    out  1  qualifies done: COUNT ended by abort
//   wrapped    out  1  qualifies done: COUNT stopped at all-ones
//   dbg_state  out  3  current FSM state (state_e encoding)
// -----------------------------------------------------------------------------
module qreg_ctrl
    import qreg_ctrl_pkg::*;
#(
    parameter int N = Q_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [N-1:0] cmd_arg,
    input  logic         abort,
    input  logic [N-1:0] q_in,
    output logic         q_clr,
    output logic         ldp,
    output logic         cta,
    output logic         l_and,
    output logic [N-1:0] sw_out,
    output logic         busy,
    output logic         done,
    output logic         aborted,
    output logic         wrapped,
    output logic [2:0]   dbg_state
);

    state_e       r_state;
    state_e       w_next_state;
    logic [N-1:0] r_sw_out;
    logic         r_aborted;
    logic         w_accept;
    logic         w_cta;
    logic         w_stop;
    logic         w_set_aborted;
    logic         w_set_wrapped;
    logic         w_cnt_zero;
    logic         w_cnt_last;
    logic         w_cnt_load;

    assign cmd_ready  = (r_state == ST_IDLE) && !rst;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_cnt_load = w_accept && (op_e'(cmd_op) == OP_COUNT);

    qreg_ctrl_cnt #(.N(N)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (cmd_arg),
        .i_dec      (w_cta),
        .o_zero     (w_cnt_zero),
        .o_last     (w_cnt_last)
    );

`ifdef QREG_CTRL_WRAP_STOP_EN
    // One more increment would roll the Q register over to zero.
    assign w_stop = (q_in == '1);
`else
    logic w_unused_q;
    assign w_unused_q = ^q_in;
    assign w_stop     = 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next state / count strobe ----------------
    always_comb begin
        w_next_state  = r_state;
        w_cta         = 1'b0;
        w_set_aborted = 1'b0;
        w_set_wrapped = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = op_to_state(op_e'(cmd_op));
                end
            end
            ST_CLR, ST_LOAD, ST_AND: begin
                w_next_state = ST_DONE;
            end
            ST_COUNT: begin
                // Priority: abort beats both the normal end and the wrap stop.
                if (abort) begin
                    w_next_state  = ST_DONE;
                    w_set_aborted = 1'b1;
                end else if (w_cnt_zero) begin
                    w_next_state = ST_DONE;
                end else if (w_stop) begin
                    w_next_state  = ST_DONE;
                    w_set_wrapped = 1'b1;
                end else begin
                    w_cta = 1'b1;
                    // Leave on the last increment so done lands at t+K+1.
                    if (w_cnt_last) begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ---------------- operand latch and done qualifiers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_out  <= '0;
            r_aborted <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sw_out <= cmd_arg;
            end
            // Set only on the COUNT->DONE edge, so it is high exactly in DONE.
            r_aborted <= w_set_aborted;
        end
    end

`ifdef QREG_CTRL_WRAP_STOP_EN
    logic r_wrapped;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrapped <= 1'b0;
        end else begin
            r_wrapped <= w_set_wrapped;
        end
    end
    assign wrapped = r_wrapped && (r_state == ST_DONE);
`else
    logic w_unused_wrap;
    assign w_unused_wrap = w_set_wrapped;
    assign wrapped       = 1'b0;
`endif

    // ---------------- outputs ----------------
    assign q_clr     = (r_state == ST_CLR);
    assign ldp       = (r_state == ST_LOAD);
    assign l_and     = (r_state == ST_AND);
    assign cta       = w_cta;
    assign sw_out    = r_sw_out;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign aborted   = r_aborted && (r_state == ST_DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_qreg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_qreg_ctrl
//   Directed bench for qreg_ctrl paired with a behavioural Q register.
//   Build with +define+QREG_CTRL_WRAP_STOP_EN to exercise the wrap-stop build.
// -----------------------------------------------------------------------------
module tb_qreg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_arg = 8'h00;
    logic       abort = 1'b0;
    logic [7:0] q_reg = 8'h00;
    logic       q_clr, ldp, cta, l_and;
    logic [7:0] sw_out;
    logic       busy, done, aborted, wrapped;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    // results of the last run_cmd
    int         r_lat, r_clr, r_ldp, r_cta, r_and, r_first, r_last_cta;
    logic [7:0] r_sw;
    logic       r_ab, r_wr;

    qreg_ctrl #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .abort     (abort),
        .q_in      (q_reg),
        .q_clr     (q_clr),
        .ldp       (ldp),
        .cta       (cta),
        .l_and     (l_and),
        .sw_out    (sw_out),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .wrapped   (wrapped),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- Q register reference ----------------
    always @(posedge clk) begin
        if (q_clr)      q_reg <= 8'h00;
        else if (ldp)   q_reg <= sw_out;
        else if (cta)   q_reg <= q_reg + 8'h01;
        else if (l_and) q_reg <= q_reg & sw_out;
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-cycle invariants.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!rst) begin
            check("onehot", 32'($countones({q_clr, ldp, cta, l_and}) <= 1), 1);
            check("ready_busy", 32'(cmd_ready & busy), 0);
            check("qual_only_done", 32'((aborted | wrapped) & ~done), 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_arg   = 8'($urandom_range(0, 255));
    endtask

    // Issue one command and watch it to completion. Iteration i samples
    // cycle t+i where t is the accept cycle.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] arg, input int abort_after);
        r_lat = 0; r_clr = 0; r_ldp = 0; r_cta = 0; r_and = 0;
        r_first = 0; r_last_cta = 0; r_sw = 8'h00; r_ab = 1'b0; r_wr = 1'b0;
        send_cmd(op, arg);
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if ((q_clr | ldp | cta | l_and) && r_first == 0) begin
                r_first = i;
                r_sw    = sw_out;
            end
            if (q_clr) r_clr++;
            if (ldp)   r_ldp++;
            if (l_and) r_and++;
            if (cta) begin
                r_cta++;
                r_last_cta = i;
            end
            if (done) begin
                r_lat = i;
                r_ab  = aborted;
                r_wr  = wrapped;
                break;
            end
            if (abort_after != 0 && cta && r_cta == abort_after) begin
                @(posedge clk);
                #1 abort = 1'b1;
            end
        end
        abort = 1'b0;
        check("done_seen", 32'(r_lat != 0), 1);
        @(negedge clk);
        check("ready_after_done", 32'(cmd_ready), 1);
        check("sw_out_hold", 32'(sw_out), 32'(arg));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_strobes", 32'({q_clr, ldp, cta, l_and, done, aborted, wrapped}), 0);
        check("rst_sw_out", 32'(sw_out), 0);
        check("rst_state", 32'(dbg_state), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(cmd_ready), 1);

        // 1: LOAD 0xA5
        run_cmd(2'b01, 8'hA5, 0);
        check("t1_first_stb", r_first, 1);
        check("t1_ldp", r_ldp, 1);
        check("t1_sw_out", 32'(r_sw), 32'h A5);
        check("t1_lat", r_lat, 2);
        check("t1_q", 32'(q_reg), 32'hA5);

        // 2: LOAD 0x10, COUNT 3
        run_cmd(2'b01, 8'h10, 0);
        run_cmd(2'b10, 8'd3, 0);
        check("t2_cta", r_cta, 3);
        check("t2_first", r_first, 1);
        check("t2_last", r_last_cta, 3);
        check("t2_lat", r_lat, 4);
        check("t2_aborted", 32'(r_ab), 0);
        check("t2_q", 32'(q_reg), 32'h13);

        // 3: COUNT 0, then CLR
        run_cmd(2'b10, 8'd0, 0);
        check("t3_cta", r_cta, 0);
        check("t3_lat", r_lat, 2);
        check("t3_q", 32'(q_reg), 32'h13);
        run_cmd(2'b00, 8'h77, 0);
        check("t3_clr", r_clr, 1);
        check("t3_clr_lat", r_lat, 2);
        check("t3_clr_q", 32'(q_reg), 32'h00);

        // 4: LOAD 0xA5, AND 0x0F
        run_cmd(2'b01, 8'hA5, 0);
        run_cmd(2'b11, 8'h0F, 0);
        check("t4_and", r_and, 1);
        check("t4_ldp", r_ldp, 0);
        check("t4_lat", r_lat, 2);
        check("t4_q", 32'(q_reg), 32'h05);

        // 5: abort in IDLE has no effect
        abort = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_abort_busy", 32'({busy, done, aborted}), 0);
            check("idle_abort_ready", 32'(cmd_ready), 1);
        end
        @(posedge clk);
        #1 abort = 1'b0;
        check("idle_abort_q", 32'(q_reg), 32'h05);

        // 5: CLR, COUNT 10 aborted after the 4th cta
        run_cmd(2'b00, 8'h00, 0);
        run_cmd(2'b10, 8'd10, 4);
        check("t5_cta", r_cta, 4);
        check("t5_aborted", 32'(r_ab), 1);
        check("t5_wrapped", 32'(r_wr), 0);
        check("t5_lat", r_lat, 6);
        check("t5_q", 32'(q_reg), 32'h04);

        // 6: LOAD 0xFD, COUNT 5 near the top of the range
        run_cmd(2'b01, 8'hFD, 0);
        run_cmd(2'b10, 8'd5, 0);
`ifdef QREG_CTRL_WRAP_STOP_EN
        check("t6_cta", r_cta, 2);
        check("t6_wrapped", 32'(r_wr), 1);
        check("t6_aborted", 32'(r_ab), 0);
        check("t6_lat", r_lat, 4);
        check("t6_q", 32'(q_reg), 32'hFF);
`else
        check("t6_cta", r_cta, 5);
        check("t6_wrapped", 32'(r_wr), 0);
        check("t6_lat", r_lat, 6);
        check("t6_q", 32'(q_reg), 32'h02);
`endif

        // Max count from zero: ends exactly at all-ones in either build
        run_cmd(2'b00, 8'h00, 0);
        run_cmd(2'b10, 8'hFF, 0);
        check("kmax_cta", r_cta, 255);
        check("kmax_lat", r_lat, 256);
        check("kmax_wrapped", 32'(r_wr), 0);
        check("kmax_q", 32'(q_reg), 32'hFF);

        // rst asserted mid-COUNT
        run_cmd(2'b00, 8'h00, 0);
        send_cmd(2'b10, 8'd20);
        repeat (3) @(negedge clk);
        check("midrst_cta_before", 32'(cta), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_outputs",
              32'({q_clr, ldp, cta, l_and, busy, done, aborted, wrapped}), 0);
        check("midrst_sw_out", 32'(sw_out), 0);
        check("midrst_state", 32'(dbg_state), 0);
        begin
            int done_snap;
            done_snap = done_cnt;
            repeat (30) @(negedge clk);
            check("midrst_no_done", done_cnt - done_snap, 0);
            check("midrst_idle", 32'({busy, cmd_ready}), 32'b01);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
